// File: rtl/count_seq_monitor_pkg.sv
// Shared types and constants for the JK sequence-counter monitor.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_e;

  // First value after counter reset, and the value that restarts each loop
  localparam logic [2:0] SEQ_START = 3'd0;
  localparam logic [2:0] SEQ_LOOP  = 3'd2;

  // Designed successor of each counter value, returned as {valid, next}.
  // Values 1, 3 and 4 are unreachable and have no successor.
  function automatic logic [3:0] seq_succ(input logic [2:0] v);
    case (v)
      3'd0:    return {1'b1, 3'd6};
      3'd6:    return {1'b1, 3'd2};
      3'd2:    return {1'b1, 3'd5};
      3'd5:    return {1'b1, 3'd7};
      3'd7:    return {1'b1, 3'd2};
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/count_seq_monitor_succ_lut.sv
// Combinational successor lookup for the monitored counter. A different
// counter variant only needs a new table here.
module seq_succ_lut
  import count_seq_pkg::*;
(
  input  logic [2:0] q,
  output logic       valid,
  output logic [2:0] next
);

  // Table lookup of the designed next value
  always_comb begin
    {valid, next} = seq_succ(q);
  end

endmodule

// File: rtl/count_seq_monitor.sv
// Monitors a 3-bit JK sequence counter: tracks lock, flags transition faults
// with a pulse and saturating count, and emits one tick per loop restart.
module count_seq_monitor
  import count_seq_pkg::*;
#(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       q_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic             period_tick,
  output logic [1:0]       state_out
);

  localparam logic [4:0]       LOCK_TGT = 5'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             tick_q, tick_d;

  logic             succ_valid;
  logic [2:0]       succ_next;
  logic             legal;
  logic             fault_inc;
  logic [4:0]       good_inc;
  logic [ERR_W-1:0] cnt_base;

  seq_succ_lut u_succ (
    .q     (prev_q),
    .valid (succ_valid),
    .next  (succ_next)
  );

  // A step is legal only if it lands on the designed successor; this also
  // rejects stalls and anything leaving an unreachable value.
  assign legal    = succ_valid && (q_in == succ_next);
  assign good_inc = {1'b0, good_cnt_q} + 5'd1;

  // Next-state logic: FSM, history, lock counter and fault counter
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    tick_d     = 1'b0;
    fault_inc  = 1'b0;
    if (en) begin
      prev_d = q_in;
      case (state_q)
        IDLE: begin
          good_cnt_d = 4'd0;
          state_d    = ACQUIRE;
        end
        ACQUIRE: begin
          if (legal) begin
            good_cnt_d = good_inc[3:0];
            if (good_inc == LOCK_TGT) state_d = LOCKED;
          end else begin
            good_cnt_d = 4'd0;
          end
        end
        LOCKED: begin
          if (legal) begin
            tick_d = (q_in == SEQ_LOOP);
          end else begin
            state_d   = FAULT;
            err_d     = 1'b1;
            fault_inc = 1'b1;
          end
        end
        default: begin
          // FAULT: one recovery sample, no legality check
          good_cnt_d = 4'd0;
          state_d    = ACQUIRE;
        end
      endcase
    end
    // Clear is applied before any same-edge increment, independent of en
    cnt_base = clr_err ? '0 : err_cnt_q;
    if (fault_inc && (cnt_base != ERR_MAX)) err_cnt_d = cnt_base + ERR_ONE;
    else                                    err_cnt_d = cnt_base;
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q    <= IDLE;
      prev_q     <= SEQ_START;
      good_cnt_q <= 4'd0;
      err_cnt_q  <= '0;
      err_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      good_cnt_q <= good_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_q      <= err_d;
      tick_q     <= tick_d;
    end
  end

  assign locked      = (state_q == LOCKED);
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign period_tick = tick_q;
  assign state_out   = state_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed table-driven bench for count_seq_monitor. Two instances share the
// stimulus: one with the default 8-bit fault counter, one with a 2-bit
// counter to exercise saturation.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       clear;
  logic       en;
  logic [2:0] q_in;
  logic       clr_err;

  logic       locked, err, period_tick;
  logic [7:0] err_cnt;
  logic [1:0] state_out;
  logic       locked2, err2, period_tick2;
  logic [1:0] err_cnt2;
  logic [1:0] state_out2;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       en;
    logic [2:0] q;
    logic       clr;
    logic       lk;
    logic       er;
    int         cnt;
    logic       tk;
    int         st;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  count_seq_monitor #(.LOCK_N(2), .ERR_W(8)) dut (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in), .clr_err(clr_err),
    .locked(locked), .err(err), .err_cnt(err_cnt),
    .period_tick(period_tick), .state_out(state_out)
  );

  count_seq_monitor #(.LOCK_N(2), .ERR_W(2)) dut_w2 (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in), .clr_err(clr_err),
    .locked(locked2), .err(err2), .err_cnt(err_cnt2),
    .period_tick(period_tick2), .state_out(state_out2)
  );

  function automatic void add(input logic e, input int q, input logic c,
                              input logic lk, input logic er, input int cnt,
                              input logic tk, input int st);
    vec_t v;
    v.en = e; v.q = 3'(q); v.clr = c;
    v.lk = lk; v.er = er; v.cnt = cnt; v.tk = tk; v.st = st;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic lk, input logic er,
                           input int cnt, input logic tk, input int st);
    int cnt2;
    cnt2 = (cnt > 3) ? 3 : cnt;
    n_vec++;
    chk("locked",      idx, int'(locked),      int'(lk));
    chk("err",         idx, int'(err),         int'(er));
    chk("err_cnt",     idx, int'(err_cnt),     cnt);
    chk("period_tick", idx, int'(period_tick), int'(tk));
    chk("state_out",   idx, int'(state_out),   st);
    chk("w2_err_cnt",  idx, int'(err_cnt2),    cnt2);
    chk("w2_locked",   idx, int'(locked2),     int'(lk));
  endtask

  task automatic run_table(input int base);
    foreach (vq[i]) begin
      @(negedge clk);
      en = vq[i].en; q_in = vq[i].q; clr_err = vq[i].clr;
      @(posedge clk);
      #1;
      check_all(base + i, vq[i].lk, vq[i].er, vq[i].cnt, vq[i].tk, vq[i].st);
    end
    vq.delete();
  endtask

  initial begin
    clear = 1'b0; en = 1'b0; q_in = 3'd0; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b1;

    // Acquire and lock from reset, tick on the second 2
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(1, 6, 0, 0, 0, 0, 0, 1);
    add(1, 2, 0, 1, 0, 0, 0, 2);
    add(1, 5, 0, 1, 0, 0, 0, 2);
    add(1, 7, 0, 1, 0, 0, 0, 2);
    add(1, 2, 0, 1, 0, 0, 1, 2);
    // Locked stream broken by 3, then relock
    add(1, 5, 0, 1, 0, 0, 0, 2);
    add(1, 7, 0, 1, 0, 0, 0, 2);
    add(1, 2, 0, 1, 0, 0, 1, 2);
    add(1, 3, 0, 0, 1, 1, 0, 3);
    add(1, 5, 0, 0, 0, 1, 0, 1);
    add(1, 7, 0, 0, 0, 1, 0, 1);
    add(1, 2, 0, 1, 0, 1, 0, 2);
    add(1, 5, 0, 1, 0, 1, 0, 2);
    // Enable low with junk on q_in: everything frozen
    add(0, 3, 0, 1, 0, 1, 0, 2);
    add(0, 1, 0, 1, 0, 1, 0, 2);
    add(0, 4, 0, 1, 0, 1, 0, 2);
    add(0, 0, 0, 1, 0, 1, 0, 2);
    add(0, 6, 0, 1, 0, 1, 0, 2);
    add(1, 7, 0, 1, 0, 1, 0, 2);
    add(1, 2, 0, 1, 0, 1, 1, 2);
    // clr_err acts while disabled
    add(0, 5, 1, 1, 0, 0, 0, 2);
    add(1, 5, 0, 1, 0, 0, 0, 2);
    // Stall while locked is a fault; FAULT lasts one sample
    add(1, 7, 0, 1, 0, 0, 0, 2);
    add(1, 7, 0, 0, 1, 1, 0, 3);
    add(1, 2, 0, 0, 0, 1, 0, 1);
    add(1, 5, 0, 0, 0, 1, 0, 1);
    add(1, 7, 0, 1, 0, 1, 0, 2);
    add(1, 2, 0, 1, 0, 1, 1, 2);
    // Four more lock-then-fault episodes: 2-bit counter saturates at 3
    for (int k = 2; k <= 5; k++) begin
      add(1, 4, 0, 0, 1, k, 0, 3);
      add(1, 5, 0, 0, 0, k, 0, 1);
      add(1, 7, 0, 0, 0, k, 0, 1);
      add(1, 2, 0, 1, 0, k, 0, 2);
    end
    // Sixth fault with clr_err on the same edge
    add(1, 4, 1, 0, 1, 1, 0, 3);
    add(1, 5, 0, 0, 0, 1, 0, 1);
    add(1, 7, 0, 0, 0, 1, 0, 1);
    run_table(1);

    // Asynchronous clear between edges while in ACQUIRE
    @(negedge clk);
    #2;
    clear = 1'b0;
    #1;
    check_all(100, 0, 0, 0, 0, 0);
    @(negedge clk);
    clear = 1'b1;

    // Start from unreachable 4: lock only after 6->2 and 2->5
    add(1, 4, 0, 0, 0, 0, 0, 1);
    add(1, 4, 0, 0, 0, 0, 0, 1);
    add(1, 6, 0, 0, 0, 0, 0, 1);
    add(1, 2, 0, 0, 0, 0, 0, 1);
    add(1, 5, 0, 1, 0, 0, 0, 2);
    run_table(101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
